// File: rtl/logic_unit_pkg.sv
// Shared op codes and the per-bit evaluation function for the pipelined logic unit.
package logic_unit_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] LU_NOT  = 3'd0;
   localparam logic [OP_W-1:0] LU_AND  = 3'd1;
   localparam logic [OP_W-1:0] LU_NAND = 3'd2;
   localparam logic [OP_W-1:0] LU_OR   = 3'd3;
   localparam logic [OP_W-1:0] LU_NOR  = 3'd4;
   localparam logic [OP_W-1:0] LU_XOR  = 3'd5;
   localparam logic [OP_W-1:0] LU_XNOR = 3'd6;
   localparam logic [OP_W-1:0] LU_PASS = 3'd7;

   // Evaluated one bit at a time.  The top replicates it across WIDTH so the
   // function stays width-agnostic and leaves no unused upper bits behind.
   function automatic logic lu_eval(input logic [OP_W-1:0] op,
                                    input logic            a,
                                    input logic            b);
      logic r;
      case (op)
         LU_NOT:  r = ~a;
         LU_AND:  r = a & b;
         LU_NAND: r = ~(a & b);
         LU_OR:   r = a | b;
         LU_NOR:  r = ~(a | b);
         LU_XOR:  r = a ^ b;
         LU_XNOR: r = ~(a ^ b);
         default: r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/logic_unit_pipe_stage.sv
// Valid/ready register slice with full throughput: it accepts new data whenever
// it is empty or its contents leave in the same cycle.
module lu_pipe_stage #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   assign in_ready = !out_valid | out_ready;

   // Valid follows the upstream offer on every advance; the data register only
   // loads when something real is being captured.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) out_data <= in_data;
      end
   end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined WIDTH-bit bitwise logic unit with result flags.
// S1 holds {op, a, b}; the op is evaluated between the slices and S2 holds
// {result, zero, ones, parity}.
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_ones,
   output logic             out_parity
);

   localparam int S1_W = OP_W + 2 * WIDTH;
   localparam int S2_W = WIDTH + 3;

   logic            s1_valid;
   logic            s2_ready;
   logic [S1_W-1:0] s1_data;
   logic [S2_W-1:0] s2_in_data;
   logic [S2_W-1:0] s2_data;

   logic [OP_W-1:0]  s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [WIDTH-1:0] result;

   lu_pipe_stage #(.DW(S1_W)) u_s1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({in_op, in_a, in_b}),
      .out_valid (s1_valid),
      .out_ready (s2_ready),
      .out_data  (s1_data)
   );

   assign s1_op = s1_data[S1_W-1 -: OP_W];
   assign s1_a  = s1_data[2*WIDTH-1 -: WIDTH];
   assign s1_b  = s1_data[WIDTH-1:0];

   // Bitwise op applied lane by lane on the S1 contents.
   always_comb begin
      result = '0;
      for (int i = 0; i < WIDTH; i++) begin
         result[i] = lu_eval(s1_op, s1_a[i], s1_b[i]);
      end
   end

   // Flags ride with the result so they are captured on the same S2 advance.
   assign s2_in_data = {result, ~|result, &result, ^result};

   lu_pipe_stage #(.DW(S2_W)) u_s2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s1_valid),
      .in_ready  (s2_ready),
      .in_data   (s2_in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (s2_data)
   );

   assign out_result = s2_data[S2_W-1 -: WIDTH];
   assign out_zero   = s2_data[2];
   assign out_ones   = s2_data[1];
   assign out_parity = s2_data[0];

endmodule
